// File: rtl/shifter_operand_pkg.sv
// Shared datapath definitions: ALU opcodes, shifter type codes and the
// operand-2 generator FSM states.
package shifter_operand_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned FIELD_W = 12;

  typedef enum logic [3:0] {
    ALU_AND = 4'h0, ALU_EOR = 4'h1, ALU_SUB = 4'h2, ALU_RSB = 4'h3,
    ALU_ADD = 4'h4, ALU_ADC = 4'h5, ALU_SBC = 4'h6, ALU_RSC = 4'h7,
    ALU_TST = 4'h8, ALU_TEQ = 4'h9, ALU_CMP = 4'hA, ALU_CMN = 4'hB,
    ALU_ORR = 4'hC, ALU_MOV = 4'hD, ALU_BIC = 4'hE, ALU_MVN = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RSREAD = 1'b1
  } state_e;

endpackage

// File: rtl/shifter_operand_barrel_shift.sv
// Combinational barrel shifter with ARM shifter carry semantics. imm_mode
// selects the shift-by-immediate meaning of a zero amount (LSR/ASR #32, RRX).
module barrel_shift
  import shifter_operand_pkg::*;
(
  input  logic [31:0] value,
  input  shift_e      shift_type,
  input  logic [7:0]  amount,
  input  logic        imm_mode,
  input  logic        c_in,
  output logic [31:0] result,
  output logic        cout
);

  logic               over;
  logic [5:0]         amt_c;
  logic [32:0]        lsl_w;
  logic [32:0]        lsr_w;
  logic signed [32:0] asr_w;
  logic [31:0]        ror_r;

  // The shifted-out bit rides in an extra LSB/MSB so carry falls out of the
  // same shift; amounts above 32 are clamped since the result is saturated.
  always_comb begin
    over  = amount > 8'd32;
    amt_c = over ? 6'd32 : amount[5:0];
    lsl_w = {1'b0, value} << amt_c;
    lsr_w = {value, 1'b0} >> amt_c;
    asr_w = $signed({value, 1'b0}) >>> amt_c;
    ror_r = (value >> amount[4:0]) | (value << (6'd32 - {1'b0, amount[4:0]}));

    result = value;
    cout   = c_in;
    if (amount == 8'd0) begin
      if (imm_mode) begin
        unique case (shift_type)
          SH_LSL: begin result = value;               cout = c_in;      end
          SH_LSR: begin result = '0;                  cout = value[31]; end
          SH_ASR: begin result = {32{value[31]}};     cout = value[31]; end
          SH_ROR: begin result = {c_in, value[31:1]}; cout = value[0];  end
        endcase
      end
    end else begin
      unique case (shift_type)
        SH_LSL: begin
          result = over ? '0 : lsl_w[31:0];
          cout   = over ? 1'b0 : lsl_w[32];
        end
        SH_LSR: begin
          result = over ? '0 : lsr_w[32:1];
          cout   = over ? 1'b0 : lsr_w[0];
        end
        SH_ASR: begin
          result = asr_w[32:1];
          cout   = asr_w[0];
        end
        SH_ROR: begin
          result = ror_r;
          cout   = ror_r[31];
        end
      endcase
    end
  end

endmodule

// File: rtl/shifter_operand.sv
// Operand-2 generator: decodes the 12-bit shifter field into the ALU second
// operand and shifter carry, with valid/ready handshakes and a result register.
module shifter_operand
  import shifter_operand_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        imm,
  input  logic [11:0] op2,
  input  logic [31:0] rm_data,
  input  logic [31:0] rs_data,
  input  logic        c_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] operand,
  output logic        carry_out
);

  state_e      state_q, state_d;
  logic [31:0] rm_q, rm_d;
  shift_e      kind_q, kind_d;
  logic        c_q, c_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] operand_q, operand_d;
  logic        carry_q, carry_d;

  logic        out_free;
  logic        accept;
  logic        is_reg;
  logic        rs_hi_unused;

  logic [31:0] bs_value;
  shift_e      bs_type;
  logic [7:0]  bs_amount;
  logic        bs_imm_mode;
  logic        bs_c_in;
  logic [31:0] bs_result;
  logic        bs_cout;

  // Only the bottom byte of Rs is a shift amount.
  always_comb begin
    rs_hi_unused = ^rs_data[31:8];
  end

  always_comb begin
    if (state_q == ST_RSREAD) begin
      bs_value    = rm_q;
      bs_type     = kind_q;
      bs_amount   = rs_data[7:0];
      bs_imm_mode = 1'b0;
      bs_c_in     = c_q;
    end else if (imm) begin
      bs_value    = {24'b0, op2[7:0]};
      bs_type     = SH_ROR;
      bs_amount   = {3'b0, op2[11:8], 1'b0};
      bs_imm_mode = 1'b0;
      bs_c_in     = c_in;
    end else begin
      bs_value    = rm_data;
      bs_type     = shift_e'(op2[6:5]);
      bs_amount   = {3'b0, op2[11:7]};
      bs_imm_mode = 1'b1;
      bs_c_in     = c_in;
    end
  end

  barrel_shift u_barrel_shift (
    .value      (bs_value),
    .shift_type (bs_type),
    .amount     (bs_amount),
    .imm_mode   (bs_imm_mode),
    .c_in       (bs_c_in),
    .result     (bs_result),
    .cout       (bs_cout)
  );

  always_comb begin
    out_free    = !out_valid_q || out_ready;
    in_ready    = (state_q == ST_IDLE) && out_free;
    accept      = in_valid && in_ready;
    is_reg      = !imm && op2[4];

    state_d     = state_q;
    rm_d        = rm_q;
    kind_d      = kind_q;
    c_d         = c_q;
    out_valid_d = out_valid_q && !out_ready;
    operand_d   = operand_q;
    carry_d     = carry_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_reg) begin
            rm_d    = rm_data;
            kind_d  = shift_e'(op2[6:5]);
            c_d     = c_in;
            state_d = ST_RSREAD;
          end else begin
            out_valid_d = 1'b1;
            operand_d   = bs_result;
            carry_d     = bs_cout;
          end
        end
      end
      ST_RSREAD: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          operand_d   = bs_result;
          carry_d     = bs_cout;
          state_d     = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rm_q        <= '0;
      kind_q      <= SH_LSL;
      c_q         <= 1'b0;
      out_valid_q <= 1'b0;
      operand_q   <= '0;
      carry_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rm_q        <= rm_d;
      kind_q      <= kind_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
      operand_q   <= operand_d;
      carry_q     <= carry_d;
    end
  end

  always_comb begin
    out_valid = out_valid_q;
    operand   = operand_q;
    carry_out = carry_q;
  end

endmodule

// File: tb/tb_shifter_operand.sv
// Randomized self-checking bench for shifter_operand against a bit-serial
// reference model and a scoreboard of expected output-register contents.
module tb_shifter_operand;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        imm;
  logic [11:0] op2;
  logic [31:0] rm_data;
  logic [31:0] rs_data;
  logic        c_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] operand;
  logic        carry_out;

  always #5 clk = ~clk;

  shifter_operand dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm       (imm),
    .op2       (op2),
    .rm_data   (rm_data),
    .rs_data   (rs_data),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .operand   (operand),
    .carry_out (carry_out)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: apply the shift one bit position at a time; the carry is the
  // last bit that left the word. Returns {carry, result}.
  function automatic logic [32:0] ref_op(input logic i, input logic [11:0] o,
                                         input logic [31:0] rm, input logic [31:0] rs,
                                         input logic ci);
    logic [31:0] v;
    logic        c;
    int unsigned n;
    logic [1:0]  t;
    if (i) begin
      v = {24'b0, o[7:0]};
      c = ci;
      n = 2 * o[11:8];
      for (int unsigned k = 0; k < n; k++) begin
        v = {v[0], v[31:1]};
        c = v[31];
      end
      return {c, v};
    end
    t = o[6:5];
    v = rm;
    c = ci;
    if (!o[4]) begin
      n = o[11:7];
      if (n == 0) begin
        case (t)
          2'd0: return {ci, rm};
          2'd1: return {rm[31], 32'h0};
          2'd2: return {rm[31], {32{rm[31]}}};
          default: return {rm[0], ci, rm[31:1]};
        endcase
      end
    end else begin
      n = rs[7:0];
    end
    for (int unsigned k = 0; k < n; k++) begin
      case (t)
        2'd0: begin c = v[31]; v = v << 1; end
        2'd1: begin c = v[0];  v = v >> 1; end
        2'd2: begin c = v[0];  v = {v[31], v[31:1]}; end
        default: begin c = v[0]; v = {v[0], v[31:1]}; end
      endcase
    end
    return {c, v};
  endfunction

  logic [32:0] out_q[$];
  logic        busy;
  logic [32:0] pend;
  logic [31:0] rs_plan;

  // One clock cycle: inputs are already driven; check, then advance the model.
  task automatic step();
    logic        acc, reg_acc, exp_valid, free;
    logic [32:0] item;
    #1;
    exp_valid = out_q.size() != 0;
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("operand", operand, out_q[0][31:0]);
      chk("carry_out", 32'(carry_out), 32'(out_q[0][32]));
    end
    free = !exp_valid || out_ready;
    chk("in_ready", 32'(in_ready), 32'(!busy && free));
    acc     = in_valid && in_ready;
    reg_acc = acc && !imm && op2[4];
    item    = ref_op(imm, op2, rm_data, rs_plan, c_in);
    @(posedge clk);
    if (exp_valid && out_ready) void'(out_q.pop_front());
    if (busy && free) begin
      out_q.push_back(pend);
      busy = 1'b0;
    end
    if (acc && !reg_acc) out_q.push_back(item);
    if (reg_acc) begin
      pend = item;
      busy = 1'b1;
    end
    #1;
    rs_data = reg_acc ? rs_plan : $urandom();
  endtask

  task automatic send(input logic i, input logic [11:0] o, input logic [31:0] rm,
                      input logic [31:0] rs, input logic ci);
    in_valid = 1'b1;
    imm      = i;
    op2      = o;
    rm_data  = rm;
    rs_plan  = rs;
    c_in     = ci;
    step();
    in_valid = 1'b0;
    rm_data  = $urandom();
    c_in     = ~ci;
    if (!i && o[4]) step();
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  lo;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    imm       = 1'b0;
    op2       = '0;
    rm_data   = '0;
    rs_data   = '0;
    rs_plan   = '0;
    c_in      = 1'b0;
    out_ready = 1'b1;
    busy      = 1'b0;
    pend      = '0;

    #12;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_operand", operand, 32'h0);
    chk("rst_carry", 32'(carry_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;

    send(1'b1, 12'h4FF, 32'h0, 32'h0, 1'b0);
    chk("imm_4ff_op", operand, 32'hFF000000);
    chk("imm_4ff_c", 32'(carry_out), 32'h1);
    send(1'b1, 12'h0AB, 32'h0, 32'h0, 1'b0);
    chk("imm_0ab_op", operand, 32'h000000AB);
    chk("imm_0ab_c", 32'(carry_out), 32'h0);

    send(1'b0, 12'h020, 32'h80000001, 32'h0, 1'b1);
    chk("lsr0_op", operand, 32'h0);
    chk("lsr0_c", 32'(carry_out), 32'h1);
    send(1'b0, 12'h060, 32'h80000001, 32'h0, 1'b1);
    chk("rrx_op", operand, 32'hC0000000);
    chk("rrx_c", 32'(carry_out), 32'h1);
    send(1'b0, 12'h040, 32'h80000001, 32'h0, 1'b1);
    chk("asr0_op", operand, 32'hFFFFFFFF);
    chk("asr0_c", 32'(carry_out), 32'h1);

    send(1'b0, 12'h010, 32'h3, 32'd32, 1'b0);
    chk("lsl32_op", operand, 32'h0);
    chk("lsl32_c", 32'(carry_out), 32'h1);
    send(1'b0, 12'h010, 32'h3, 32'd33, 1'b1);
    chk("lsl33_op", operand, 32'h0);
    chk("lsl33_c", 32'(carry_out), 32'h0);
    send(1'b0, 12'h070, 32'h3, 32'd64, 1'b1);
    chk("ror64_op", operand, 32'h3);
    chk("ror64_c", 32'(carry_out), 32'h0);

    // Backpressure with back-to-back requests, then release.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    imm       = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op2 = 12'($urandom());
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();

    // Reset while a register-specified shift is waiting for Rs.
    in_valid = 1'b1;
    imm      = 1'b0;
    op2      = 12'h015;
    rm_data  = 32'h12345678;
    rs_plan  = 32'd4;
    step();
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rsread_rst_valid", 32'(out_valid), 32'h0);
    chk("rsread_rst_op", operand, 32'h0);
    chk("rsread_rst_c", 32'(carry_out), 32'h0);
    out_q.delete();
    busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rsread_rel_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    repeat (3) step();

    for (int i = 0; i < 1500; i++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      imm       = 1'($urandom());
      op2       = 12'($urandom());
      c_in      = 1'($urandom());
      case ($urandom_range(0, 3))
        0: rm_data = 32'h80000001;
        1: rm_data = 32'h7FFFFFFE;
        default: rm_data = $urandom();
      endcase
      r = $urandom();
      case ($urandom_range(0, 7))
        0: lo = 8'd0;
        1: lo = 8'd31;
        2: lo = 8'd32;
        3: lo = 8'd33;
        4: lo = 8'd64;
        5: lo = 8'($urandom_range(1, 31));
        default: lo = r[7:0];
      endcase
      rs_plan = {r[31:8], lo};
      step();
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
